// File: rtl/snes_bus_sync.sv
// Purpose : SNES cartridge bus front end; sync + glitch filter, access strobes, joypad register snoop.
// Latency : raw edge -> filtered level after 2+FILTER_LEN clk, edge strobes one clk later; read strobe RD_DELAY after /RD falls.
// Backpress: none; the SNES bus cannot be stalled, consumers must accept every one-cycle strobe.
//
// Ports:
//   clk, rst                          system clock, synchronous active-high reset
//   SNES_CPU_CLK_in/READ_in/WRITE_in/RESET_in  raw asynchronous bus controls (/RD,/WR,/RESET active low)
//   SNES_ADDR[23:0], SNES_DATA[7:0]   raw address / write-data buses
//   SNES_cycle_start/rd/wr/reset_strobe  one-cycle registered strobes
//   SNES_ADDR_r, SNES_DATA_r          captured address / write data
//   pad_latch, snes_ajr               joypad snoop state
module snes_bus_sync #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned RD_DELAY   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SNES_CPU_CLK_in,
  input  logic        SNES_READ_in,
  input  logic        SNES_WRITE_in,
  input  logic        SNES_RESET_in,
  input  logic [23:0] SNES_ADDR,
  input  logic [7:0]  SNES_DATA,
  output logic        SNES_cycle_start,
  output logic        SNES_rd_strobe,
  output logic        SNES_wr_strobe,
  output logic        SNES_reset_strobe,
  output logic [23:0] SNES_ADDR_r,
  output logic [7:0]  SNES_DATA_r,
  output logic        pad_latch,
  output logic        snes_ajr
);

  // Channel indices into the packed per-input vectors.
  localparam int CH_CLK = 0;
  localparam int CH_RD  = 1;
  localparam int CH_WR  = 2;
  localparam int CH_RST = 3;

  // Idle levels: CPU clock low, /RD and /WR deasserted, SNES held in reset.
  localparam logic [3:0] PRESET  = 4'b0110;
  localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN);
  localparam logic [4:0] RD_LOAD = 5'(RD_DELAY);

  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      filt_q, filt_d, filt_dly_q;
  logic [3:0][3:0] fcnt_q, fcnt_d;
  logic [3:0]      rise, fall;

  logic [4:0]  rd_cnt_q, rd_cnt_d;
  logic        rd_fire, wr_fire;
  logic        in_reset, rd_low, wr_low;
  logic        cyc_stb_q, rd_stb_q, wr_stb_q, rst_stb_q;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        pad_q, pad_d, ajr_q, ajr_d;
  logic        sys_bank;

  assign raw = {SNES_RESET_in, SNES_WRITE_in, SNES_READ_in, SNES_CPU_CLK_in};

  // Glitch filter: the synchronised level must disagree with the filtered
  // level for FILTER_LEN consecutive samples before the filtered level flips.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == FLT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign rise     = filt_q & ~filt_dly_q;
  assign fall     = ~filt_q & filt_dly_q;
  assign in_reset = ~filt_q[CH_RST];
  assign rd_low   = ~filt_q[CH_RD];
  assign wr_low   = ~filt_q[CH_WR];

  // Read countdown: loaded on /RD fall, fires once on its 1->0 step.
  // Reset, an active /WR or /RD release all cancel a pending read.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_fire  = 1'b0;
    if (in_reset || wr_low || !rd_low) begin
      rd_cnt_d = '0;
    end else if (fall[CH_RD]) begin
      rd_cnt_d = RD_LOAD;
    end else if (rd_cnt_q != 5'd0) begin
      rd_cnt_d = rd_cnt_q - 5'd1;
      rd_fire  = (rd_cnt_q == 5'd1);
    end
  end

  assign wr_fire = rise[CH_WR] & ~in_reset;

  // Write data is tracked for the whole /WR low window so the last sample
  // before /WR rises is what the snoop and consumers see.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (wr_low) begin
      addr_d = SNES_ADDR;
      data_d = SNES_DATA;
    end else if (rd_fire) begin
      addr_d = SNES_ADDR;
    end
  end

  assign sys_bank = ~addr_q[22];

  always_comb begin
    pad_d = pad_q;
    ajr_d = ajr_q;
    if (in_reset) begin
      pad_d = 1'b0;
      ajr_d = 1'b0;
    end else begin
      if (wr_stb_q && sys_bank && addr_q[15:0] == 16'h4016 && data_q[0]) pad_d = 1'b1;
      if (rd_stb_q && addr_q == 24'h00FFEA) pad_d = 1'b0;
      if (wr_stb_q && sys_bank && addr_q[15:0] == 16'h4200) ajr_d = data_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= PRESET;
      sync2_q    <= PRESET;
      filt_q     <= PRESET;
      filt_dly_q <= PRESET;
      fcnt_q     <= '0;
      rd_cnt_q   <= '0;
      cyc_stb_q  <= 1'b0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      rst_stb_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      pad_q      <= 1'b0;
      ajr_q      <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      fcnt_q     <= fcnt_d;
      rd_cnt_q   <= rd_cnt_d;
      cyc_stb_q  <= rise[CH_CLK];
      rd_stb_q   <= rd_fire;
      wr_stb_q   <= wr_fire;
      rst_stb_q  <= rise[CH_RST];
      addr_q     <= addr_d;
      data_q     <= data_d;
      pad_q      <= pad_d;
      ajr_q      <= ajr_d;
    end
  end

  assign SNES_cycle_start  = cyc_stb_q;
  assign SNES_rd_strobe    = rd_stb_q;
  assign SNES_wr_strobe    = wr_stb_q;
  assign SNES_reset_strobe = rst_stb_q;
  assign SNES_ADDR_r       = addr_q;
  assign SNES_DATA_r       = data_q;
  assign pad_latch         = pad_q;
  assign snes_ajr          = ajr_q;

endmodule

// File: tb/tb_snes_bus_sync.sv
// Purpose : directed self-checking bench for snes_bus_sync (FILTER_LEN=3, RD_DELAY=6).
// Latency : inputs driven 1 time unit after a rising clk edge, outputs sampled at the same point.
// Backpress: n/a.
module tb_snes_bus_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_clk, rd_n, wr_n, reset_n;
  logic [23:0] addr;
  logic [7:0]  data;
  logic        cyc_stb, rd_stb, wr_stb, rst_stb;
  logic [23:0] addr_r;
  logic [7:0]  data_r;
  logic        pad, ajr;

  int n_checks = 0;
  int n_err    = 0;
  int n_cyc = 0, n_rd = 0, n_wr = 0, n_rst = 0;
  int base_rd, base_wr, base_rst, base_cyc;

  snes_bus_sync #(.FILTER_LEN(3), .RD_DELAY(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .SNES_CPU_CLK_in   (cpu_clk),
    .SNES_READ_in      (rd_n),
    .SNES_WRITE_in     (wr_n),
    .SNES_RESET_in     (reset_n),
    .SNES_ADDR         (addr),
    .SNES_DATA         (data),
    .SNES_cycle_start  (cyc_stb),
    .SNES_rd_strobe    (rd_stb),
    .SNES_wr_strobe    (wr_stb),
    .SNES_reset_strobe (rst_stb),
    .SNES_ADDR_r       (addr_r),
    .SNES_DATA_r       (data_r),
    .pad_latch         (pad),
    .snes_ajr          (ajr)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (cyc_stb) n_cyc++;
    if (rd_stb)  n_rd++;
    if (wr_stb)  n_wr++;
    if (rst_stb) n_rst++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write access: /WR low 6 clk, then high. wr_strobe lands 6 clk after the
  // rising edge is driven (2 sync + 3 filter + 1 strobe register); the snoop
  // result appears one clk after that.
  task automatic do_write(input logic [23:0] a, input logic [7:0] d,
                          input logic exp_pad, input logic exp_ajr);
    addr = a;
    data = d;
    wr_n = 1'b0;
    ticks(6);
    wr_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) check("wr_early", {39'd0, wr_stb}, 40'd0);
      if (i == 6) begin
        check("wr_strobe", {39'd0, wr_stb}, 40'd1);
        check("wr_addr", {16'd0, addr_r}, {16'd0, a});
        check("wr_data", {32'd0, data_r}, {32'd0, d});
      end
      if (i == 7) begin
        check("wr_strobe_len", {39'd0, wr_stb}, 40'd0);
        check("snoop_pad", {39'd0, pad}, {39'd0, exp_pad});
        check("snoop_ajr", {39'd0, ajr}, {39'd0, exp_ajr});
      end
    end
  endtask

  // Long read: /RD low 20 clk. Filtered fall at edge 5, load at 6, strobe at
  // 6+RD_DELAY = 12; pad_latch reacts at 13.
  task automatic do_read(input logic [23:0] a, input logic pad_before, input logic pad_after);
    base_rd = n_rd;
    addr = a;
    rd_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 11) check("rd_early", {39'd0, rd_stb}, 40'd0);
      if (i == 12) begin
        check("rd_strobe", {39'd0, rd_stb}, 40'd1);
        check("rd_addr", {16'd0, addr_r}, {16'd0, a});
        check("pad_before_clr", {39'd0, pad}, {39'd0, pad_before});
      end
      if (i == 13) begin
        check("rd_strobe_len", {39'd0, rd_stb}, 40'd0);
        check("pad_after_rd", {39'd0, pad}, {39'd0, pad_after});
      end
    end
    rd_n = 1'b1;
    ticks(10);
    check("rd_count_one", n_rd - base_rd, 40'd1);
  endtask

  initial begin
    rst     = 1'b1;
    cpu_clk = 1'b0;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    reset_n = 1'b0;
    addr    = 24'h0;
    data    = 8'h0;

    // Reset held with every raw input toggling: all outputs stay 0.
    for (int i = 0; i < 4; i++) begin
      cpu_clk = ~cpu_clk;
      rd_n    = ~rd_n;
      wr_n    = ~wr_n;
      reset_n = ~reset_n;
      addr    = ~addr;
      data    = ~data;
      tick();
      check("reset_outputs",
            {2'b00, cyc_stb, rd_stb, wr_stb, rst_stb, addr_r, data_r, pad, ajr}, 40'd0);
    end
    cpu_clk = 1'b0;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    reset_n = 1'b0;
    addr    = 24'h0;
    data    = 8'h0;
    tick();
    rst = 1'b0;

    // SNES still in reset: accesses produce no rd/wr strobes.
    base_rd = n_rd;
    base_wr = n_wr;
    addr = 24'h00FFEA;
    rd_n = 1'b0;
    ticks(20);
    rd_n = 1'b1;
    ticks(10);
    addr = 24'h004016;
    data = 8'h01;
    wr_n = 1'b0;
    ticks(6);
    wr_n = 1'b1;
    ticks(10);
    check("rd_suppressed", n_rd - base_rd, 40'd0);
    check("wr_suppressed", n_wr - base_wr, 40'd0);
    check("pad_in_reset", {39'd0, pad}, 40'd0);

    // 2-sample /RESET glitch is filtered out.
    base_rst = n_rst;
    reset_n = 1'b1;
    ticks(2);
    reset_n = 1'b0;
    ticks(10);
    check("reset_glitch", n_rst - base_rst, 40'd0);

    // /RESET release: strobe after edge 6 only (2 sync + 3 filter + 1).
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("reset_strobe", {39'd0, rst_stb}, {39'd0, (i == 6)});
    end
    ticks(5);

    // Latch joypads via $80:4016 D0=1, then NMI vector fetch clears it.
    do_write(24'h804016, 8'h01, 1'b1, 1'b0);
    do_read(24'h00FFEA, 1'b1, 1'b0);

    // Short /RD pulse: 5 filtered clk low, countdown aborted, no strobe.
    base_rd = n_rd;
    addr = 24'h00FFEA;
    rd_n = 1'b0;
    ticks(5);
    rd_n = 1'b1;
    ticks(20);
    check("rd_short_pulse", n_rd - base_rd, 40'd0);

    // $C0:4016 is not a system bank: pad_latch stays 0.
    do_write(24'hC04016, 8'h01, 1'b0, 1'b0);

    // Auto-joypad enable tracks $4200 bit 0.
    do_write(24'h004200, 8'h81, 1'b0, 1'b1);
    do_write(24'h004200, 8'h80, 1'b0, 1'b0);
    do_write(24'h004200, 8'h81, 1'b0, 1'b1);

    // Asserting /RESET forces snes_ajr low (filtered low at 5, cleared at 6).
    reset_n = 1'b0;
    ticks(5);
    check("ajr_before_reset", {39'd0, ajr}, 40'd1);
    ticks(3);
    check("ajr_held_reset", {39'd0, ajr}, 40'd0);

    // CPU clock ~2.67 MHz against 96 MHz: 36 clk per period, SNES in reset.
    base_cyc = n_cyc;
    cpu_clk = 1'b1;
    ticks(18);
    cpu_clk = 1'b0;
    ticks(18);
    check("cycle_start_one", n_cyc - base_cyc, 40'd1);
    for (int p = 1; p < 1000; p++) begin
      cpu_clk = 1'b1;
      ticks(18);
      cpu_clk = 1'b0;
      ticks(18);
    end
    check("cycle_start_1000", n_cyc - base_cyc, 40'd1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
